cas_decode_sched: RTL

- Round-robin scheduler that shares one registered "case-decode" datapath among NREQ requesters.
- Each requester presents a 1-bit selector `a` and a 3-bit pattern code `b`.
- The scheduler grants one requester at a time, runs the decode and returns the 3-bit result `c` and flag `d`, tagged with the requester id, over a valid/ready handshake.
- Sits between the per-channel request logic and the shared decoder, so the decoder is never duplicated per channel.

---
 rtl/cas_decode_sched_pkg.sv | 22 ++
 rtl/cas_decode_core.sv | 24 ++
 rtl/cas_decode_sched.sv | 112 +++++++++++
 3 files changed

// File: rtl/cas_decode_sched_pkg.sv
// Shared types and constants for the case-decode scheduler.
package cas_decode_sched_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Pattern with don't-care bits: a bit takes part in the match only where msk is 1.
  typedef struct packed {
    logic [2:0] val;
    logic [2:0] msk;
  } pat_t;

  localparam pat_t PAT_10X = '{val: 3'b100, msk: 3'b110};
  localparam pat_t PAT_0X1 = '{val: 3'b001, msk: 3'b101};

  localparam logic [2:0] C_THREE = 3'b011;
  localparam logic [2:0] C_TWO   = 3'b010;

  function automatic logic pat_match(input logic [2:0] b, input pat_t p);
    return (b & p.msk) == p.val;
  endfunction

endpackage

// File: rtl/cas_decode_core.sv
// Combinational case-decode table; first matching pattern wins.
module cas_decode_core
  import cas_decode_sched_pkg::*;
(
  input  logic       a,
  input  logic [2:0] b,
  output logic [2:0] c_next,
  output logic       d_next
);

  // Default row first, then the prioritised patterns override it.
  always_comb begin
    c_next = C_TWO;
    d_next = a;
    if (pat_match(b, PAT_10X)) begin
      d_next = 1'b1;
      c_next = a ? C_THREE : 3'b000;
    end else if (pat_match(b, PAT_0X1)) begin
      d_next = 1'b0;
      c_next = C_TWO;
    end
  end

endmodule

// File: rtl/cas_decode_sched.sv
// Round-robin scheduler sharing one registered case-decode datapath among NREQ requesters.
module cas_decode_sched
  import cas_decode_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_a,
  input  logic [3*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [2:0]        c,
  output logic              d,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  state_t          state, state_n;
  logic [ID_W-1:0] ptr, win;
  logic            op_a;
  logic [2:0]      op_b;
  logic [2:0]      c_next;
  logic            d_next;

  // First set request bit searching upward from p+1, wrapping around.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [ID_W-1:0] p);
    logic [ID_W-1:0] w;
    logic            found;
    int              idx;
    w     = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(p) + i) % NREQ;
      if (!found && r[idx]) begin
        w     = ID_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win  = rr_pick(req, ptr);
  assign busy = (state != IDLE);

  cas_decode_core u_core (
    .a      (op_a),
    .b      (op_b),
    .c_next (c_next),
    .d_next (d_next)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state: grant on any request, one decode cycle, then wait for acceptance.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|req) state_n = EXEC;
      EXEC:    state_n = RESP;
      RESP:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand capture on grant, decode register in EXEC, result handshake in RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      c         <= '0;
      d         <= 1'b0;
      done_cnt  <= '0;
      ptr       <= ID_W'(NREQ - 1);
      op_a      <= 1'b0;
      op_b      <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: if (|req) begin
          op_a   <= req_a[win];
          op_b   <= req_b[3*win +: 3];
          out_id <= win;
          ptr    <= win;
          gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
        end
        EXEC: begin
          c         <= c_next;
          d         <= d_next;
          out_valid <= 1'b1;
        end
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          if (done_cnt != '1) done_cnt <= done_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
